pipe_share_sched: RTL and testbench

- Round-robin scheduler that shares one fixed-latency pipeline datapath (a pipe_reg chain of depth PIPE) among NREQ requesters.
- Grants at most one requester per cycle and drives the winner's operand into the datapath.
- Carries a valid bit and requester ID alongside the datapath with matching latency, so each returning result is routed back with its owner's ID.
- Provides a drain/quiesce sequence for reconfiguration and tracks in-flight occupancy.

---
 rtl/pipe_share_sched_pkg.sv | 20 ++
 rtl/pipe_reg.sv | 25 ++
 rtl/pipe_share_sched_rr_arbiter.sv | 38 +++
 rtl/pipe_share_sched.sv | 113 +++++++++++
 tb/tb_pipe_share_sched.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/pipe_share_sched_pkg.sv
// Shared types and helpers for the pipe_share_sched scheduler and its arbiter.
package pipe_share_sched_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    QUIET = 2'd2
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  localparam int PIPE_DEFAULT = 4;
  localparam int CNTW         = clog2(PIPE_DEFAULT + 1);

endpackage

// File: rtl/pipe_reg.sv
// Generic register chain of depth pipe; every stage clears on reset.
module pipe_reg #(
  parameter int bitwidth = 8,
  parameter int pipe     = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [bitwidth-1:0] i_d,
  output logic [bitwidth-1:0] o_q
);

  logic [bitwidth-1:0] r_stage [pipe];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < pipe; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < pipe; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[pipe-1];

endmodule

// File: rtl/pipe_share_sched_rr_arbiter.sv
// Round-robin arbiter: lowest requesting index at or above the pointer wins, wrapping mod NREQ.
module rr_arbiter
  import pipe_share_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  input  logic            i_en,
  output logic [NREQ-1:0] o_gnt,
  output logic [IDW-1:0]  o_id,
  output logic            o_any
);

  logic [IDW:0]   w_sum;
  logic [IDW-1:0] w_idx;

  always_comb begin
    o_gnt = '0;
    o_id  = '0;
    o_any = 1'b0;
    w_sum = '0;
    w_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      // One extra bit holds ptr+i before the mod-NREQ fold, so non-power-of-two NREQ wraps correctly.
      w_sum = {1'b0, i_ptr} + (IDW+1)'(i);
      if (w_sum >= (IDW+1)'(NREQ)) w_sum = w_sum - (IDW+1)'(NREQ);
      w_idx = w_sum[IDW-1:0];
      if (i_en && !o_any && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        o_id         = w_idx;
        o_any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_share_sched.sv
// Shares one fixed-latency datapath among NREQ requesters; a tag pipe of matching depth
// returns each result with its owner's ID. Includes a drain/quiesce handshake.
module pipe_share_sched
  import pipe_share_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int BW   = 8,
  parameter int PIPE = PIPE_DEFAULT,
  parameter int IDW  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*BW-1:0]         req_data,
  output logic [NREQ-1:0]            gnt,
  output logic [BW-1:0]              dp_data_in,
  input  logic [BW-1:0]              dp_data_out,
  output logic                       rsp_valid,
  output logic [IDW-1:0]             rsp_id,
  output logic [BW-1:0]              rsp_data,
  input  logic                       drain_req,
  output logic                       drain_done,
  output logic [clog2(PIPE+1)-1:0]   inflight,
  output logic                       busy
);

  localparam int IFW = clog2(PIPE + 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [IDW-1:0]   r_ptr;
  logic [IFW-1:0]   r_inflight;
  logic             r_drain_done;
  logic             w_grant_en;
  logic [NREQ-1:0]  w_gnt;
  logic [IDW-1:0]   w_id;
  logic             w_any;
  logic [BW-1:0]    w_dp_data;
  logic [IDW:0]     w_tag_d;
  logic [IDW:0]     w_tag_q;

  // Grants are gated off during reset so no op is launched while state is being cleared.
  assign w_grant_en = (r_state == RUN) && !rst;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .i_req (req),
    .i_ptr (r_ptr),
    .i_en  (w_grant_en),
    .o_gnt (w_gnt),
    .o_id  (w_id),
    .o_any (w_any)
  );

  always_comb begin
    w_dp_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_gnt[k]) w_dp_data = req_data[k*BW +: BW];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (drain_req) w_state_nxt = DRAIN;
      DRAIN: begin
        if (!drain_req)              w_state_nxt = RUN;
        else if (r_inflight == '0)   w_state_nxt = QUIET;
      end
      QUIET:   if (!drain_req) w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= RUN;
      r_ptr        <= '0;
      r_inflight   <= '0;
      r_drain_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_drain_done <= (w_state_nxt == QUIET);
      r_inflight   <= r_inflight + IFW'(w_any) - IFW'(rsp_valid);
      if (w_any) r_ptr <= (w_id == IDW'(NREQ-1)) ? '0 : w_id + 1'b1;
    end
  end

  // Tag path: {valid, id} travels in lockstep with the shared datapath.
  assign w_tag_d = {w_any, w_id};

  pipe_reg #(
    .bitwidth (IDW + 1),
    .pipe     (PIPE)
  ) u_tag (
    .clk (clk),
    .rst (rst),
    .i_d (w_tag_d),
    .o_q (w_tag_q)
  );

  assign gnt        = w_gnt;
  assign dp_data_in = w_dp_data;
  assign rsp_valid  = w_tag_q[IDW];
  assign rsp_id     = w_tag_q[IDW-1:0];
  assign rsp_data   = dp_data_out;
  assign drain_done = r_drain_done;
  assign inflight   = r_inflight;
  assign busy       = (r_inflight != '0);

endmodule

// File: tb/tb_pipe_share_sched.sv
// Bench for pipe_share_sched: directed request patterns with a pipe_reg loopback datapath
// and a queue-based response scoreboard.
module tb_pipe_share_sched;

  localparam int NREQ = 4;
  localparam int BW   = 8;
  localparam int PIPE = 4;
  localparam int IDW  = 2;

  typedef struct {
    logic [IDW-1:0] id;
    logic [BW-1:0]  data;
    int             due;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*BW-1:0] req_data;
  logic [NREQ-1:0]   gnt;
  logic [BW-1:0]     dp_data_in;
  logic [BW-1:0]     dp_data_out;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [BW-1:0]     rsp_data;
  logic              drain_req;
  logic              drain_done;
  logic [2:0]        inflight;
  logic              busy;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  exp_t q[$];
  exp_t mon_e;
  logic mon_ev;
  logic [BW-1:0] opnd [NREQ];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipe_share_sched #(
    .NREQ (NREQ), .BW (BW), .PIPE (PIPE), .IDW (IDW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_data    (req_data),
    .gnt         (gnt),
    .dp_data_in  (dp_data_in),
    .dp_data_out (dp_data_out),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .rsp_data    (rsp_data),
    .drain_req   (drain_req),
    .drain_done  (drain_done),
    .inflight    (inflight),
    .busy        (busy)
  );

  pipe_reg #(.bitwidth (BW), .pipe (PIPE)) u_loop (
    .clk (clk),
    .rst (rst),
    .i_d (dp_data_in),
    .o_q (dp_data_out)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input logic [NREQ-1:0] r, input logic d);
    @(posedge clk);
    #1;
    req       = r;
    drain_req = d;
    @(negedge clk);
  endtask

  // Check the grant and operand for this cycle; a granted op is queued for its response.
  task automatic expg(input logic [NREQ-1:0] eg, input int einf, input string tag);
    int k;
    logic [BW-1:0] ed;
    k  = -1;
    ed = '0;
    for (int i = 0; i < NREQ; i++) if (eg[i]) begin k = i; ed = opnd[i]; end
    chk({tag, " gnt"}, int'(gnt), int'(eg));
    chk({tag, " dp_data_in"}, int'(dp_data_in), int'(ed));
    if (einf >= 0) chk({tag, " inflight"}, int'(inflight), einf);
    if (k >= 0) q.push_back('{id: IDW'(k), data: ed, due: cyc + PIPE});
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon_ev = (q.size() > 0) && (q[0].due == cyc);
      chk("rsp_valid", int'(rsp_valid), int'(mon_ev));
      if (mon_ev) begin
        mon_e = q.pop_front();
        if (rsp_valid) begin
          chk("rsp_id", int'(rsp_id), int'(mon_e.id));
          chk("rsp_data", int'(rsp_data), int'(mon_e.data));
        end
      end
    end
  end

  initial begin
    int inf_d [7];
    int dd_d  [7];
    inf_d = '{4, 3, 2, 1, 0, 0, 0};
    dd_d  = '{0, 0, 0, 0, 0, 1, 1};
    opnd  = '{8'h11, 8'h22, 8'h5A, 8'h33};
    req_data  = {opnd[3], opnd[2], opnd[1], opnd[0]};
    rst       = 1'b1;
    req       = '0;
    drain_req = 1'b0;

    repeat (2) @(negedge clk);
    chk("reset gnt", int'(gnt), 0);
    chk("reset dp_data_in", int'(dp_data_in), 0);
    chk("reset rsp_valid", int'(rsp_valid), 0);
    chk("reset rsp_id", int'(rsp_id), 0);
    chk("reset inflight", int'(inflight), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset drain_done", int'(drain_done), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single request from requester 2.
    drive(4'b0100, 1'b0); expg(4'b0100, 0, "single");
    for (int i = 0; i < 4; i++) begin
      drive(4'b0000, 1'b0); expg(4'b0000, 1, "single idle");
    end

    // Sparse 1001 from pointer 3: 3,0,3,0,3.
    drive(4'b1001, 1'b0); expg(4'b1000, 0, "sparse");
    drive(4'b1001, 1'b0); expg(4'b0001, 1, "sparse");
    drive(4'b1001, 1'b0); expg(4'b1000, 2, "sparse");
    drive(4'b1001, 1'b0); expg(4'b0001, 3, "sparse");
    drive(4'b1001, 1'b0); expg(4'b1000, 4, "sparse");

    // All requesting, pointer just past 3: 0,1,2,3,0,1,2,3 at full occupancy.
    for (int i = 0; i < 8; i++) begin
      drive(4'b1111, 1'b0); expg(4'(1 << (i % 4)), 4, "all");
    end

    // Drain raised at full occupancy: one last grant, then quiesce.
    drive(4'b1111, 1'b1); expg(4'b0001, 4, "drain rise");
    for (int i = 0; i < 7; i++) begin
      drive(4'b1111, 1'b1); expg(4'b0000, inf_d[i], "draining");
      chk("draining drain_done", int'(drain_done), dd_d[i]);
    end
    chk("quiet busy", int'(busy), 0);
    drive(4'b1111, 1'b0); expg(4'b0000, 0, "drain release");
    chk("release drain_done", int'(drain_done), 1);
    drive(4'b1111, 1'b0); expg(4'b0010, 0, "resume");
    chk("resume drain_done", int'(drain_done), 0);

    // Drain cancelled after two cycles with three ops in flight.
    drive(4'b1111, 1'b0); expg(4'b0100, 1, "pre-cancel");
    drive(4'b1111, 1'b0); expg(4'b1000, 2, "pre-cancel");
    drive(4'b1111, 1'b1); expg(4'b0001, 3, "cancel rise");
    drive(4'b1111, 1'b1); expg(4'b0000, 4, "cancel drain");
    chk("cancel drain_done", int'(drain_done), 0);
    drive(4'b1111, 1'b0); expg(4'b0000, 3, "cancel drop");
    chk("cancel drop drain_done", int'(drain_done), 0);
    drive(4'b1111, 1'b0); expg(4'b0010, 2, "cancel resume");
    chk("cancel resume drain_done", int'(drain_done), 0);
    drive(4'b1111, 1'b0); expg(4'b0100, 2, "cancel run");
    drive(4'b1111, 1'b0); expg(4'b1000, 2, "cancel run");

    // Reset with three ops in flight: tags discarded, pointer back to 0.
    @(posedge clk);
    #1;
    rst = 1'b1;
    req = 4'b1111;
    q.delete();
    @(negedge clk);
    chk("rst-mid gnt", int'(gnt), 0);
    chk("rst-mid inflight", int'(inflight), 3);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    expg(4'b0001, 0, "post-rst");
    drive(4'b1111, 1'b0); expg(4'b0010, 1, "post-rst");
    drive(4'b1111, 1'b0); expg(4'b0100, 2, "post-rst");
    drive(4'b1111, 1'b0); expg(4'b1000, 3, "post-rst");
    for (int i = 0; i < 5; i++) begin
      drive(4'b0000, 1'b0); expg(4'b0000, 4 - i, "tail");
    end
    chk("tail busy", int'(busy), 0);
    chk("responses outstanding", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
